// File: rtl/mxint_pkg.sv
// Shared widths and helpers for the MXInt dequantiser.
// Saturation constants feed the MXINT_DEQUANT_SAT_EN build.
package mxint_pkg;

    localparam int MXINT_MAN_WIDTH = 8;
    localparam int MXINT_EXP_WIDTH = 6;
    localparam int MXINT_OUT_WIDTH = 16;

    function automatic int clamp_shift(input int sh, input int lo, input int hi);
        if (sh < lo) return lo;
        if (sh > hi) return hi;
        return sh;
    endfunction

    function automatic logic [63:0] sat_max(input int w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] sat_min(input int w);
        return ~sat_max(w);
    endfunction

endpackage

// File: rtl/mxint_shift_sat.sv
// One lane: shift mantissa by a clamped signed amount.
// MXINT_DEQUANT_SAT_EN saturates on left-shift overflow, else wraps.
module mxint_shift_sat
    import mxint_pkg::*;
#(
    parameter int MAN_WIDTH = MXINT_MAN_WIDTH,
    parameter int OUT_WIDTH = MXINT_OUT_WIDTH,
    parameter int SH_W      = MXINT_EXP_WIDTH + 2
) (
    input  logic [MAN_WIDTH-1:0]   m,
    input  logic signed [SH_W-1:0] sh,
    output logic [OUT_WIDTH-1:0]   res
);

    logic signed [OUT_WIDTH-1:0] m_o;
    logic [SH_W-1:0] amt;

    assign m_o = {{(OUT_WIDTH - MAN_WIDTH){m[MAN_WIDTH-1]}}, m};
    assign amt = sh[SH_W-1] ? SH_W'(-sh) : sh;

`ifdef MXINT_DEQUANT_SAT_EN
    localparam int PW = MAN_WIDTH + OUT_WIDTH;
    localparam logic [OUT_WIDTH-1:0] SAT_MAX = OUT_WIDTH'(sat_max(OUT_WIDTH));
    localparam logic [OUT_WIDTH-1:0] SAT_MIN = OUT_WIDTH'(sat_min(OUT_WIDTH));

    logic signed [PW-1:0] prod;
    logic [PW-OUT_WIDTH:0] top;
    logic ovf;

    // Exact product: every bit above the result sign must match it.
    assign prod = {{OUT_WIDTH{m[MAN_WIDTH-1]}}, m} <<< amt;
    assign top  = prod[PW-1:OUT_WIDTH-1];
    assign ovf  = !((&top) || !(|top));

    always_comb begin
        res = prod[OUT_WIDTH-1:0];
        if (sh[SH_W-1]) res = m_o >>> amt;
        else if (ovf) res = m[MAN_WIDTH-1] ? SAT_MIN : SAT_MAX;
    end
`else
    always_comb begin
        res = m_o << amt;
        if (sh[SH_W-1]) res = m_o >>> amt;
    end
`endif

endmodule

// File: rtl/mxint_dequant.sv
// MXInt block dequantiser: two registered stages, valid/ready, full backpressure.
// Optional MXINT_DEQUANT_SAT_EN selects saturating lanes.
module mxint_dequant
    import mxint_pkg::*;
#(
    parameter int IN_SIZE   = 2,
    parameter int MAN_WIDTH = MXINT_MAN_WIDTH,
    parameter int EXP_WIDTH = MXINT_EXP_WIDTH,
    parameter int OUT_WIDTH = 16,
    parameter int OUT_FRAC  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [MAN_WIDTH-1:0] man_in [IN_SIZE],
    input  logic [EXP_WIDTH-1:0] exp_in,
    input  logic                 data_in_valid,
    output logic                 data_in_ready,
    output logic [OUT_WIDTH-1:0] data_out [IN_SIZE],
    output logic                 data_out_valid,
    input  logic                 data_out_ready
);

    localparam int SPAN  = (OUT_WIDTH > MAN_WIDTH) ? OUT_WIDTH : MAN_WIDTH;
    localparam int SH_MN = $clog2(SPAN + 1) + 1;
    localparam int SH_W  = (EXP_WIDTH + 2 > SH_MN) ? EXP_WIDTH + 2 : SH_MN;

    logic                   s1_valid;
    logic                   s1_ready;
    logic [MAN_WIDTH-1:0]   s1_man [IN_SIZE];
    logic signed [SH_W-1:0] s1_sh;
    logic signed [SH_W-1:0] sh_clamped;
    logic [OUT_WIDTH-1:0]   lane_res [IN_SIZE];

    assign sh_clamped = SH_W'(clamp_shift(
        int'($signed(exp_in)) + OUT_FRAC - (MAN_WIDTH - 1),
        -MAN_WIDTH, OUT_WIDTH));

    assign s1_ready      = !data_out_valid || data_out_ready;
    assign data_in_ready = !s1_valid || s1_ready;

    for (genvar g = 0; g < IN_SIZE; g++) begin : g_lane
        mxint_shift_sat #(
            .MAN_WIDTH(MAN_WIDTH),
            .OUT_WIDTH(OUT_WIDTH),
            .SH_W     (SH_W)
        ) u_lane (
            .m  (s1_man[g]),
            .sh (s1_sh),
            .res(lane_res[g])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_valid       <= 1'b0;
            data_out_valid <= 1'b0;
            s1_sh          <= '0;
            for (int i = 0; i < IN_SIZE; i++) begin
                s1_man[i]   <= '0;
                data_out[i] <= '0;
            end
        end else begin
            if (data_in_ready) begin
                s1_valid <= data_in_valid;
                if (data_in_valid) begin
                    s1_man <= man_in;
                    s1_sh  <= sh_clamped;
                end
            end
            if (s1_ready) begin
                data_out_valid <= s1_valid;
                if (s1_valid) data_out <= lane_res;
            end
        end
    end

endmodule

// File: tb/tb_mxint_dequant.sv
// Directed bench for mxint_dequant (IN_SIZE=2, 8-bit mantissa, Q8.8 out).
// Overflow expectations follow MXINT_DEQUANT_SAT_EN.
module tb_mxint_dequant;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  man_in [2];
    logic [5:0]  exp_in;
    logic        data_in_valid;
    logic        data_in_ready;
    logic [15:0] data_out [2];
    logic        data_out_valid;
    logic        data_out_ready;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    mxint_dequant #(
        .IN_SIZE(2), .MAN_WIDTH(8), .EXP_WIDTH(6),
        .OUT_WIDTH(16), .OUT_FRAC(8)
    ) dut (
        .clk(clk), .rst(rst), .man_in(man_in), .exp_in(exp_in),
        .data_in_valid(data_in_valid), .data_in_ready(data_in_ready),
        .data_out(data_out), .data_out_valid(data_out_valid),
        .data_out_ready(data_out_ready)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input int a, input int b, input int e);
        man_in[0]     = 8'(a);
        man_in[1]     = 8'(b);
        exp_in        = 6'(e);
        data_in_valid = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        data_in_valid = 1'b0;
        data_out_ready = 1'b1;
        man_in[0] = '0; man_in[1] = '0; exp_in = '0;
        step(); step();
        checks++;
        if (data_out_valid !== 1'b0)
            $display("FAIL reset_valid: got %b want 0", data_out_valid);
        else passed++;
        checks++;
        if ({data_out[0], data_out[1]} !== 32'h0)
            $display("FAIL reset_data: got %h %h want 0 0", data_out[0], data_out[1]);
        else passed++;
        rst = 1'b1;
        #1;
        checks++;
        if (data_in_ready !== 1'b1)
            $display("FAIL reset_ready: got %b want 1", data_in_ready);
        else passed++;
    endtask

    task automatic test_exact();
        data_out_ready = 1'b1;
        present(64, -128, 1);
        step();
        present(64, -128, 0);
        #1;
        checks++;
        if (data_out_valid !== 1'b0)
            $display("FAIL exact_latency: valid got %b want 0", data_out_valid);
        else passed++;
        step();
        data_in_valid = 1'b0;
        checks++;
        if (data_out_valid !== 1'b1 || {data_out[0], data_out[1]} !== {16'h0100, 16'hFE00})
            $display("FAIL exact_e1: got v=%b %h %h want 1 0100 fe00",
                     data_out_valid, data_out[0], data_out[1]);
        else passed++;
        step();
        checks++;
        if (data_out_valid !== 1'b1 || {data_out[0], data_out[1]} !== {16'h0080, 16'hFF00})
            $display("FAIL exact_e0: got v=%b %h %h want 1 0080 ff00",
                     data_out_valid, data_out[0], data_out[1]);
        else passed++;
        step();
        checks++;
        if (data_out_valid !== 1'b0)
            $display("FAIL exact_drain: valid got %b want 0", data_out_valid);
        else passed++;
    endtask

    task automatic test_right_shift();
        data_out_ready = 1'b1;
        present(100, -100, -5);
        step();
        present(3, -3, -20);
        step();
        data_in_valid = 1'b0;
        checks++;
        if (data_out_valid !== 1'b1 || {data_out[0], data_out[1]} !== {16'h0006, 16'hFFF9})
            $display("FAIL floor_shift: got v=%b %h %h want 1 0006 fff9",
                     data_out_valid, data_out[0], data_out[1]);
        else passed++;
        step();
        checks++;
        if (data_out_valid !== 1'b1 || {data_out[0], data_out[1]} !== {16'h0000, 16'hFFFF})
            $display("FAIL right_clamp: got v=%b %h %h want 1 0000 ffff",
                     data_out_valid, data_out[0], data_out[1]);
        else passed++;
        step();
    endtask

    task automatic test_overflow();
        logic [31:0] want;
`ifdef MXINT_DEQUANT_SAT_EN
        want = {16'h7FFF, 16'h8000};
`else
        want = {16'hF800, 16'h0000};
`endif
        data_out_ready = 1'b1;
        present(127, -128, 10);
        step();
        data_in_valid = 1'b0;
        step();
        checks++;
        if (data_out_valid !== 1'b1 || {data_out[0], data_out[1]} !== want)
            $display("FAIL overflow: got v=%b %h %h want 1 %h",
                     data_out_valid, data_out[0], data_out[1], want);
        else passed++;
        step();
    endtask

    task automatic test_backpressure();
        int sent = 0;
        int rcv = 0;
        int cyc = 0;
        logic [31:0] exp_blk [4];
        // e=0 -> sh=1, so each lane doubles.
        for (int i = 0; i < 4; i++)
            exp_blk[i] = {16'(2 * (10 + i)), 16'(-2 * (10 + i))};
        data_out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if (sent < 4) present(10 + sent, -(10 + sent), 0);
            else data_in_valid = 1'b0;
            #1;
            if (c >= 2) begin
                checks++;
                if (data_out_valid !== 1'b1 || {data_out[0], data_out[1]} !== exp_blk[0])
                    $display("FAIL stall_hold: cyc %0d got v=%b %h %h want 1 %h",
                             c, data_out_valid, data_out[0], data_out[1], exp_blk[0]);
                else passed++;
            end
            if (data_in_valid && data_in_ready) sent++;
            step();
        end
        checks++;
        if (sent !== 2 || data_in_ready !== 1'b0)
            $display("FAIL stall_accepts: got %0d rdy=%b want 2 rdy=0", sent, data_in_ready);
        else passed++;
        data_out_ready = 1'b1;
        while ((rcv < 4 || sent < 4) && cyc < 20) begin
            if (sent < 4) present(10 + sent, -(10 + sent), 0);
            else data_in_valid = 1'b0;
            #1;
            if (data_out_valid && data_out_ready) begin
                checks++;
                if (rcv >= 4 || {data_out[0], data_out[1]} !== exp_blk[rcv & 3])
                    $display("FAIL bp_order: beat %0d got %h %h want %h",
                             rcv, data_out[0], data_out[1], exp_blk[rcv & 3]);
                else passed++;
                rcv++;
            end
            if (data_in_valid && data_in_ready) sent++;
            step();
            cyc++;
        end
        data_in_valid = 1'b0;
        #1;
        checks++;
        if (rcv !== 4 || data_out_valid !== 1'b0)
            $display("FAIL bp_count: got %0d beats v=%b want 4 v=0", rcv, data_out_valid);
        else passed++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] want;
        data_out_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            if (c < 8) present(3 * c + 1, -5 * c, 1);
            else data_in_valid = 1'b0;
            #1;
            if (c < 8) begin
                checks++;
                if (data_in_ready !== 1'b1)
                    $display("FAIL b2b_ready: cyc %0d got %b want 1", c, data_in_ready);
                else passed++;
            end
            if (c >= 2 && c < 10) begin
                want = {16'(4 * (3 * (c - 2) + 1)), 16'(-20 * (c - 2))};
                checks++;
                if (data_out_valid !== 1'b1 || {data_out[0], data_out[1]} !== want)
                    $display("FAIL b2b_beat: cyc %0d got v=%b %h %h want 1 %h",
                             c, data_out_valid, data_out[0], data_out[1], want);
                else passed++;
            end else begin
                checks++;
                if (data_out_valid !== 1'b0)
                    $display("FAIL b2b_idle: cyc %0d got v=%b want 0", c, data_out_valid);
                else passed++;
            end
            step();
        end
    endtask

    task automatic test_reset_mid();
        data_out_ready = 1'b0;
        present(50, -50, 0);
        step();
        present(60, -60, 0);
        step();
        data_in_valid = 1'b0;
        rst = 1'b0;
        step();
        checks++;
        if (data_out_valid !== 1'b0 || {data_out[0], data_out[1]} !== 32'h0)
            $display("FAIL midrst_clear: got v=%b %h %h want 0 0000 0000",
                     data_out_valid, data_out[0], data_out[1]);
        else passed++;
        rst = 1'b1;
        data_out_ready = 1'b1;
        #1;
        checks++;
        if (data_in_ready !== 1'b1)
            $display("FAIL midrst_ready: got %b want 1", data_in_ready);
        else passed++;
        present(64, -128, 1);
        step();
        data_in_valid = 1'b0;
        checks++;
        if (data_out_valid !== 1'b0)
            $display("FAIL midrst_stale: got v=%b want 0", data_out_valid);
        else passed++;
        step();
        checks++;
        if (data_out_valid !== 1'b1 || {data_out[0], data_out[1]} !== {16'h0100, 16'hFE00})
            $display("FAIL midrst_fresh: got v=%b %h %h want 1 0100 fe00",
                     data_out_valid, data_out[0], data_out[1]);
        else passed++;
        step();
    endtask

    initial begin
        test_reset();
        test_exact();
        test_right_shift();
        test_overflow();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/mxint_dequant.md
Name: mxint_dequant

Overview:
- Decoder end of the MXInt block format: takes one block of IN_SIZE signed mantissas plus the shared exponent and reconstructs IN_SIZE signed fixed-point values.
- The shared exponent is the ceil(log2(max|x|)) value produced on the encode side.
- Sits downstream of MXInt storage/compute, feeding fixed-point datapaths.
- Two-stage registered pipeline with a valid/ready handshake and full backpressure.

Parameters:
- IN_SIZE, 2, mantissas per block (lanes).
- MAN_WIDTH, 8, signed mantissa width; the mantissa is read as a fraction m/2^(MAN_WIDTH-1).
- EXP_WIDTH, 6, signed two's-complement shared-exponent width.
- OUT_WIDTH, 16, signed fixed-point output width.
- OUT_FRAC, 8, fractional bits of the output.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  synchronous active-low reset.
- man_in  input  [MAN_WIDTH-1:0] x IN_SIZE (unpacked)  block mantissas.
- exp_in  input  EXP_WIDTH  shared exponent, signed.
- data_in_valid  input  1  block valid.
- data_in_ready  output  1  block accepted when valid && ready.
- data_out  output  [OUT_WIDTH-1:0] x IN_SIZE (unpacked)  dequantised values.
- data_out_valid  output  1  output valid.
- data_out_ready  input  1  downstream ready.

Behaviour:
- Value: out = m * 2^(e - (MAN_WIDTH-1) + OUT_FRAC). Define sh = e + OUT_FRAC - (MAN_WIDTH-1) as a signed quantity at least EXP_WIDTH+2 bits wide.
- sh >= 0: arithmetic left shift of m.
- sh < 0: arithmetic right shift of m (floor, toward -inf).
- Clamp sh to [-MAN_WIDTH, OUT_WIDTH].
  - Right-clamp result: 0 for m >= 0, -1 for m < 0.
  - Left-clamp result: all OUT_WIDTH bits shifted out.
- Stage 1, on input accept: register all mantissas and clamped sh. Set s1_valid.
- Stage 2, on s1 transfer: per-lane shift and overflow handling, register to data_out. Set data_out_valid.
- Latency: 2 cycles from accept to data_out_valid when the pipe is unstalled.
- Throughput: 1 block/cycle.
- Ready chain, combinational, no bubble:
  - s1_ready = !data_out_valid || data_out_ready
  - data_in_ready = !s1_valid || s1_ready
- Stall: data_out and data_out_valid hold stable while valid && !ready.
- With a full stall, the pipe holds 2 blocks. data_in_ready drops only when both stages are full.
- Simultaneous accept on input and output: both stages advance the same cycle. No loss, no duplication.
- Reset (rst=0 at a clock edge):
  - s1_valid=0, data_out_valid=0, data_out lanes = 0.
  - data_in_ready reads 1 in the first cycle after reset release.
  - Any in-flight blocks are discarded, including mid-stall.
- Lanes are independent and share sh. Exponent is unused when all mantissas are 0 (output 0).

Optional Feature:
- Macro MXINT_DEQUANT_SAT_EN.
- Defined: on left-shift overflow (any lost bit differs from the result sign), the lane saturates to 2^(OUT_WIDTH-1)-1 for positive m, or -2^(OUT_WIDTH-1) for negative m.
- Undefined: the lane wraps and keeps the low OUT_WIDTH bits of the exact product.
- Latency and handshake are identical either way.

Decomposition:
- Package mxint_pkg:
  - default widths (MXINT_MAN_WIDTH=8, MXINT_EXP_WIDTH=6)
  - function clamp_shift
  - saturation min/max constants derived from OUT_WIDTH
- One combinational sub-module, mxint_shift_sat: a single lane with m and sh in, OUT_WIDTH result out, saturation gated by the macro.
- The top instantiates IN_SIZE lanes in a generate loop and owns both pipeline registers and the handshake.

Test Plan (IN_SIZE=2, MAN_WIDTH=8, EXP_WIDTH=6, OUT_WIDTH=16, OUT_FRAC=8):
- Exact values: m={64,-128}, e=1 then e=0 -> {256,-512} then {128,-256}, each valid 2 cycles after accept.
- Right shift / floor: m={100,-100}, e=-5 (sh=-4) -> {6,-7}; m={3,-3}, e=-20 (clamped) -> {0,-1}.
- Overflow: m={127,-128}, e=10 (sh=11).
  - With SAT_EN: {0x7FFF, 0x8000}.
  - Without SAT_EN: {0xF800, 0x0000}.
- Backpressure: stream 4 blocks, hold data_out_ready=0 for 5 cycles.
  - data_in_ready falls after exactly 2 accepts.
  - data_out stays stable while stalled.
  - All 4 blocks emerge in order after release, with no loss or duplication.
- Full throughput with ready=1: 8 back-to-back blocks give 8 consecutive output beats, starting 2 cycles after the first accept.
- Reset mid-operation: rst=0 with 2 blocks in flight.
  - Next cycle: data_out_valid=0 and data_out=0.
  - After release: data_in_ready=1, and a fresh block produces the correct result.
